mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file: consumes its two read-data outputs (rs value as a, rt value as b).
- Its hi/lo outputs feed the writeback mux for MFHI/MFLO.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake, so the pipeline can stall on a busy unit.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- a  input  WIDTH  operand 1: rs value, dividend, or MTHI/MTLO data.
- b  input  WIDTH  operand 2: rt value, divisor.
- cancel  input  1  aborts an in-flight MULT/DIV.
- busy  output  1  high while a MULT/DIV is in progress.
- done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
- hi  output  WIDTH  HI register, registered output.
- lo  output  WIDTH  LO register, registered output.

Behaviour:
- Reset: rst low forces the following immediately, regardless of clk:
  - hi=0, lo=0, busy=0, done=0
  - state=IDLE, iteration counter=0, internal datapath registers=0.
  - Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op=MTHI writes hi<=a at the edge; no busy, no done.
  - start=1 with op=MTLO writes lo<=a at the edge; no busy, no done.
  - start=1 with op in 000..011:
    - Latch operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops use the value as is.
    - Latch the result-sign flags and the op type.
    - Clear the counter; go to CALC. busy=1 from the next cycle.
  - start=1 with op 110/111: no effect.
- CALC:
  - One radix-2 iteration per cycle, WIDTH iterations in total.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After iteration WIDTH-1, go to FIX.
- FIX (one cycle):
  - Apply sign correction and write hi/lo.
  - Go to IDLE; done=1 and busy=0 in the following cycle.
- Latency (start sampled at edge E0):
  - busy high after E0 through E33 exclusive.
  - hi/lo updated at E33; done high for exactly the cycle after E33.
  - Total: 34 cycles from start cycle to done cycle.
- Result mapping:
  - Multiply: {hi,lo} = product. Signed: negate the 2*WIDTH product if operand signs differ.
  - Divide: lo = quotient, hi = remainder. Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Boundary conditions:
  - Signed most-negative / -1: lo = 0x80000000, hi = 0. No trap.
  - Divide by zero (DIV or DIVU): lo = all ones, hi = a unchanged. Full latency is kept.
  - start while busy=1 is ignored, including MTHI/MTLO; the pipeline must stall instead.
  - cancel=1 in CALC or FIX: return to IDLE at the next edge; hi/lo are untouched; no done pulse. cancel in IDLE has no effect.
  - cancel and start in the same IDLE cycle: start wins.
  - hi/lo hold their values throughout CALC. Reads during busy return the pre-operation values.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC as soon as the remaining unshifted multiplier bits are all zero. At least one iteration is always performed.
  - The accumulator is aligned as if all WIDTH iterations had run.
  - Latency = iterations + 2 cycles from start cycle to done cycle.
  - Divide is unaffected.
- Not defined: every MULT/MULTU takes exactly WIDTH iterations (34-cycle latency).

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high throughout the intervening cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MDU_EARLY_OUT_EN, MULTU a=5, b=3 -> done 4 cycles after start; hi=0, lo=15.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after 34 cycles. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Sequence:
  - MTHI a=0xAAAA5555 -> hi updates the next cycle with no busy.
  - Start MULT 6*7 and assert MTLO start at cycle 5 -> MTLO is ignored.
  - Assert cancel at cycle 10 -> busy low next cycle; no done; hi=0xAAAA5555 and lo unchanged.
- Start DIV, drop rst at cycle 20 asynchronously (between edges) -> hi=lo=0, busy=done=0 immediately. After release, a new MULTU 2*3 -> lo=6.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use a radix-2 shift-add datapath. DIV/DIVU use a restoring
// shift-subtract datapath. Both run WIDTH iterations, then one FIX cycle.
// MTHI/MTLO write HI/LO directly when the unit is idle.
// Optional build macro MDU_EARLY_OUT_EN: a multiply leaves CALC as soon as
// no multiplier bits remain to be processed.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: running product. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiply: multiplicand shifted left each step. Divide: divisor in low half.
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    // Multiply: multiplier bits not yet consumed (shifted right each step).
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;   // negate product / quotient
    logic               neg_r_q, neg_r_d;   // negate remainder
    logic               dz_q, dz_d;         // divide by zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes: signed ops (op[0]=0) take the absolute value.
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               signs_differ;
    assign signed_op    = ~op[0];
    assign mag_a        = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b        = (signed_op && b[WIDTH-1]) ? -b : b;
    assign signs_differ = a[WIDTH-1] ^ b[WIDTH-1];

    // One restoring-division step: shift remainder left, trial subtract.
    logic [WIDTH:0]     rem_sh, trial;
    assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};

    // Sign-corrected results applied in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = neg_q_q ? -acc_q : acc_q;
    assign quot_fix = dz_q ? {WIDTH{1'b1}}
                    : (neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Leave CALC after the final iteration (or early, for a finished multiply).
    logic calc_last;
`ifdef MDU_EARLY_OUT_EN
    assign calc_last = (cnt_q == CW'(WIDTH - 1)) ||
                       (!is_div_q && (mplr_q[WIDTH-1:1] == '0));
`else
    assign calc_last = (cnt_q == CW'(WIDTH - 1));
`endif

    // Next-state logic: op dispatch, per-iteration datapath, result write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU: begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, mag_a};
                            mplr_d   = mag_b;
                            is_div_d = 1'b0;
                            neg_q_d  = signed_op & signs_differ;
                            neg_r_d  = 1'b0;
                            dz_d     = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, mag_a};
                            mcand_d  = {{WIDTH{1'b0}}, mag_b};
                            mplr_d   = '0;
                            is_div_d = 1'b1;
                            neg_q_d  = signed_op & signs_differ;
                            neg_r_d  = signed_op & a[WIDTH-1];
                            dz_d     = (b == '0);
                            cnt_d    = '0;
                            state_d  = S_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!trial[WIDTH]) begin
                            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (mplr_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_q >> 1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (calc_last) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; asynchronous active-low reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo. Expected HI/LO and completion
// cycle are queued at issue time; a monitor pops them on every done pulse.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {hi, lo} straight from integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, q, m;
        longint unsigned ux, uy, uq, um;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        r = 64'd0;
        case (o)
            3'd0: r = sx * sy;
            3'd1: r = ux * uy;
            3'd2: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else begin
                    uq = ux / uy;
                    um = ux % uy;
                    r = {um[31:0], uq[31:0]};
                end
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int latency(input logic [2:0] o, input logic [31:0] y);
        int n;
        logic [31:0] mb;
        n = 32;
`ifdef MDU_EARLY_OUT_EN
        if (o == 3'd0 || o == 3'd1) begin
            mb = (o == 3'd0 && y[31]) ? -y : y;
            n = 0;
            for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
            if (n == 0) n = 1;
        end
`else
        mb = y;
`endif
        return n + 2;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Issue a MULT/DIV, queue its expectation, and follow it until idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic with_cancel, input string name);
        logic [31:0] h0, l0;
        logic [63:0] r;
        int bc, lat;
        logic hold_ok;
        exp_t e;
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        cancel = with_cancel;
        r = ref_model(o, x, y);
        lat = latency(o, y);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.due = cyc + lat;
        e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        a = $urandom;
        b = $urandom;
        bc = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            bc++;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(bc), 64'(lat - 1));
        check({name, "_hilo_hold"}, 64'(hold_ok), 64'd1);
    endtask

    // MTHI/MTLO or an ignored op: single-cycle, never busy.
    task automatic mt_op(input logic [2:0] o, input logic [31:0] x, input string name);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op = o;
        a = x;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        if (o == 3'd4)      check({name, "_hilo"}, {hi, lo}, {x, l0});
        else if (o == 3'd5) check({name, "_hilo"}, {hi, lo}, {h0, x});
        else                check({name, "_hilo"}, {hi, lo}, {h0, l0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x, y, l_save;
        logic [2:0]  o;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b1;

        // Directed cases
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_m3x7");
        check("mult_m3x7_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(3'd1, 32'd5, 32'd3, 1'b0, "multu_5x3");
        check("multu_5x3_const", {hi, lo}, 64'h00000000_0000000F);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, "div_m7d2");
        check("div_m7d2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd3, 32'd7, 32'd2, 1'b0, "divu_7d2");
        check("divu_7d2_const", {hi, lo}, 64'h00000001_00000003);
        run_op(3'd3, 32'h00001234, 32'd0, 1'b0, "divu_by0");
        check("divu_by0_const", {hi, lo}, 64'h00001234_FFFFFFFF);
        run_op(3'd2, 32'hFFFFFF00, 32'd0, 1'b0, "div_neg_by0");
        check("div_neg_by0_const", {hi, lo}, 64'hFFFFFF00_FFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_minneg");
        check("div_minneg_const", {hi, lo}, 64'h00000000_80000000);
        run_op(3'd0, 32'd9, 32'd11, 1'b1, "mult_start_cancel");
        mt_op(3'd6, 32'h13579BDF, "op110_ignored");
        mt_op(3'd7, 32'h2468ACE0, "op111_ignored");

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 6))
                0: y = 32'd0;
                1: y = 32'($urandom_range(0, 15));
                2: y = 32'hFFFFFFFF;
                3: x = 32'h80000000;
                default: ;
            endcase
            run_op(o, x, y, 1'($urandom_range(0, 3) == 0), "rand");
        end

        // MTHI, ignored MTLO while busy, cancel mid-multiply
        mt_op(3'd4, 32'hAAAA5555, "mthi");
        l_save = lo;
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        a = 32'd6;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = 3'd5;
        a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_while_busy_lo", 64'(lo), 64'(l_save));
        check("mtlo_while_busy_busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hilo", {hi, lo}, {32'hAAAA5555, l_save});
        repeat (40) @(negedge clk);
        check("cancel_no_done_hilo", {hi, lo}, {32'hAAAA5555, l_save});

        // Asynchronous reset mid-divide
        @(negedge clk);
        start = 1'b1;
        op = 3'd2;
        a = 32'h7FFF0001;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        run_op(3'd1, 32'd2, 32'd3, 1'b0, "multu_2x3");
        check("multu_2x3_const", {hi, lo}, 64'h00000000_00000006);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
